// File: rtl/css_pkg.sv
// Shared types and constants for the pipelined carry-skip subtractor.
package css_pkg;
  localparam int DATA_W  = 16;
  localparam int SLICE_W = 4;
  localparam int STAGES  = 4;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic              valid;
    logic              carry;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } css_stage_t;
endpackage

// File: rtl/css_slice_4bit.sv
// Combinational 4-bit carry-skip slice: sum = a + b_inv + cin, cout skips the ripple when all bits propagate.
module css_slice_4bit
  import css_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b_inv,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  always_comb begin
    p    = a ^ b_inv;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) c[i+1] = (a[i] & b_inv[i]) | (p[i] & c[i]);
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = (&p) ? cin : c[SLICE_W];
endmodule

// File: rtl/carry_skip_sub_pipe_16bit.sv
// Pipelined 16-bit subtractor (a - b - bin), one carry-skip slice per stage, valid/ready both sides.
// Optional: define CSS_SATURATE_EN to clamp diff on signed overflow in the last stage.
module carry_skip_sub_pipe_16bit
  import css_pkg::*;
#(
  parameter int STAGES  = 4,
  parameter int SLICE_W = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int L = STAGES - 1;

  generate
    if (STAGES != css_pkg::STAGES || SLICE_W * STAGES != DATA_W) begin : g_bad_cfg
      $error("carry_skip_sub_pipe_16bit supports only STAGES=4, SLICE_W=4");
    end
  endgenerate

  css_stage_t st [STAGES];

  logic [STAGES-1:0]              vld, adv, src_valid, src_cin, sl_cout;
  logic [STAGES-1:0][DATA_W-1:0]  src_a, src_b, src_diff, nxt_diff;
  logic [STAGES-1:0][SLICE_W-1:0] sl_a, sl_bi, sl_sum;
  logic [DATA_W-1:0]              last_diff;
  logic                           last_ovf, bout_q, ovf_q;

  // adv[k] closed-form: a stage moves if it or anything downstream has a hole, or the sink drains
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      assign vld[k] = st[k].valid;
      assign adv[k] = out_ready | ~(&vld[STAGES-1:k]);

      if (k == 0) begin : g_in
        assign src_valid[k] = in_valid;
        assign src_cin[k]   = ~bin;
        assign src_a[k]     = a;
        assign src_b[k]     = b;
        assign src_diff[k]  = '0;
      end else begin : g_fwd
        assign src_valid[k] = st[k-1].valid;
        assign src_cin[k]   = st[k-1].carry;
        assign src_a[k]     = st[k-1].a;
        assign src_b[k]     = st[k-1].b;
        assign src_diff[k]  = st[k-1].diff;
      end

      assign sl_a[k]  = src_a[k][k*SLICE_W +: SLICE_W];
      assign sl_bi[k] = ~src_b[k][k*SLICE_W +: SLICE_W];

      css_slice_4bit u_slice (
        .a     (sl_a[k]),
        .b_inv (sl_bi[k]),
        .cin   (src_cin[k]),
        .sum   (sl_sum[k]),
        .cout  (sl_cout[k])
      );

      always_comb begin
        nxt_diff[k]                     = src_diff[k];
        nxt_diff[k][k*SLICE_W +: SLICE_W] = sl_sum[k];
      end
    end
  endgenerate

  assign in_ready = adv[0];

  assign last_ovf = (src_a[L][DATA_W-1] != src_b[L][DATA_W-1]) &
                    (nxt_diff[L][DATA_W-1] != src_a[L][DATA_W-1]);

`ifdef CSS_SATURATE_EN
  assign last_diff = last_ovf ? (src_a[L][DATA_W-1] ? SAT_NEG : SAT_POS) : nxt_diff[L];
`else
  assign last_diff = nxt_diff[L];
`endif

  // Data only loads with a valid token, so idle stages keep their last contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) st[i] <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          st[i].valid <= src_valid[i];
          if (src_valid[i]) begin
            st[i].carry <= sl_cout[i];
            st[i].diff  <= (i == L) ? last_diff : nxt_diff[i];
            st[i].a     <= src_a[i];
            st[i].b     <= src_b[i];
          end
        end
      end
      if (adv[L] && src_valid[L]) begin
        bout_q <= ~sl_cout[L];
        ovf_q  <= last_ovf;
      end
    end
  end

  assign out_valid = st[L].valid;
  assign diff      = st[L].diff;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_carry_skip_sub_pipe_16bit.sv
// Scoreboard bench for carry_skip_sub_pipe_16bit: directed vectors, backpressure, random, reset mid-flight.
module tb_carry_skip_sub_pipe_16bit;
  logic        clk = 1'b0, rst = 1'b1, rst_nx = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic        bin = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, bout, ovf;
  logic [15:0] diff;

  carry_skip_sub_pipe_16bit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] d; logic bo; logic ov; } exp_t;
  typedef struct { logic [15:0] a, b; logic bi; logic [15:0] d; logic bo, ov; } vec_t;

  exp_t        q[$];
  int          total = 0, bad = 0;
  logic [15:0] s_diff;
  logic        s_bout, s_ovf, s_ovalid, s_iready;

  function automatic exp_t model(logic [15:0] x, logic [15:0] y, logic bi);
    logic [16:0] f;
    exp_t e;
    f    = {1'b0, x} - {1'b0, y} - {16'b0, bi};
    e.d  = f[15:0];
    e.bo = f[16];
    e.ov = (x[15] != y[15]) && (f[15] != x[15]);
`ifdef CSS_SATURATE_EN
    if (e.ov) e.d = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  // Drive on the falling edge, sample 1ns later, then let the rising edge happen.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                      input logic ordy, output logic acc, output logic emit);
    @(negedge clk);
    rst = rst_nx; in_valid = iv; a = ia; b = ib; bin = ibin; out_ready = ordy;
    #1;
    s_diff = diff; s_bout = bout; s_ovf = ovf; s_ovalid = out_valid; s_iready = in_ready;
    acc  = iv && in_ready && !rst;
    emit = out_valid && ordy && !rst;
    if (acc) q.push_back(model(ia, ib, ibin));
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic acc, emit;
    rst_nx = 1'b1;
    repeat (3) step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b1, acc, emit);
    rst_nx = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, emit);
    total++; if (s_ovalid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", s_ovalid); end
    total++; if (s_diff !== 16'h0000) begin bad++; $display("FAIL reset_diff got=%h want=0000", s_diff); end
    total++; if (s_bout !== 1'b0 || s_ovf !== 1'b0) begin bad++; $display("FAIL reset_flags bout=%b ovf=%b want=0/0", s_bout, s_ovf); end
    total++; if (s_iready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", s_iready); end
    q.delete();
  endtask

  task automatic test_directed();
    vec_t vt[7];
    logic acc, emit;
    int   lat;
    exp_t e;
    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[6] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
`ifdef CSS_SATURATE_EN
      if (vt[i].ov) vt[i].d = vt[i].a[15] ? 16'h8000 : 16'h7FFF;
`endif
      step(1'b1, vt[i].a, vt[i].b, vt[i].bi, 1'b1, acc, emit);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL dir%0d_accept got=%b want=1", i, acc); end
      lat = 0;
      emit = 1'b0;
      while (!emit && lat < 12) begin
        step(1'b0, '0, '0, 1'b0, 1'b1, acc, emit);
        lat++;
      end
      total++;
      if (!emit) begin
        bad++; $display("FAIL dir%0d_timeout no out_valid within %0d cycles", i, lat);
      end else begin
        if (q.size() > 0) e = q.pop_front();
        if (lat != 4 || s_diff !== vt[i].d || s_bout !== vt[i].bo || s_ovf !== vt[i].ov) begin
          bad++;
          $display("FAIL dir%0d got lat=%0d diff=%h bout=%b ovf=%b want lat=4 diff=%h bout=%b ovf=%b",
                   i, lat, s_diff, s_bout, s_ovf, vt[i].d, vt[i].bo, vt[i].ov);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] oa[6], ob[6];
    logic        acc, emit, early;
    int          i, got;
    exp_t        e;
    for (int j = 0; j < 6; j++) begin oa[j] = 16'h1000 * j[15:0] + 16'h0777; ob[j] = 16'h0101 * j[15:0]; end
    i = 0; early = 1'b0;
    repeat (8) begin
      step(i < 6, oa[i % 6], ob[i % 6], i[0], 1'b0, acc, emit);
      if (acc) i++;
      if (s_ovalid && emit) early = 1'b1;
    end
    total++; if (i != 4) begin bad++; $display("FAIL bp_accepts got=%0d want=4", i); end
    total++; if (s_iready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", s_iready); end
    total++; if (s_ovalid !== 1'b1 || early) begin bad++; $display("FAIL bp_hold out_valid=%b early_emit=%b want 1/0", s_ovalid, early); end
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      step(i < 6, oa[i % 6], ob[i % 6], i[0], 1'b1, acc, emit);
      if (acc) i++;
      if (emit) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL bp_extra result diff=%h with empty scoreboard", s_diff);
        end else begin
          e = q.pop_front();
          if (s_diff !== e.d || s_bout !== e.bo || s_ovf !== e.ov) begin
            bad++; $display("FAIL bp_result%0d got=%h/%b/%b want=%h/%b/%b", got, s_diff, s_bout, s_ovf, e.d, e.bo, e.ov);
          end
        end
        got++;
      end
    end
    total++; if (got != 6 || q.size() != 0) begin bad++; $display("FAIL bp_count got=%0d left=%0d want=6/0", got, q.size()); end
  endtask

  task automatic test_random();
    logic        acc, emit, pend, ordy, stall;
    logic [15:0] ra, rb, hd;
    logic        rbi, hbo, hov;
    int          sent, c;
    exp_t        e;
    sent = 0; pend = 1'b0; stall = 1'b0; ra = '0; rb = '0; rbi = 1'b0; hd = '0; hbo = 1'b0; hov = 1'b0;
    for (c = 0; c < 20000; c++) begin
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom_range(0, 1)); pend = 1'b1;
      end
      ordy = ($urandom_range(0, 3) != 0);
      step(pend, ra, rb, rbi, ordy, acc, emit);
      if (stall) begin
        total++;
        if (s_ovalid !== 1'b1 || s_diff !== hd || s_bout !== hbo || s_ovf !== hov) begin
          bad++; $display("FAIL rnd_stable got v=%b %h/%b/%b want v=1 %h/%b/%b", s_ovalid, s_diff, s_bout, s_ovf, hd, hbo, hov);
        end
      end
      stall = s_ovalid && !ordy;
      hd = s_diff; hbo = s_bout; hov = s_ovf;
      if (acc) begin sent++; pend = 1'b0; end
      if (emit) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_extra result diff=%h with empty scoreboard", s_diff);
        end else begin
          e = q.pop_front();
          if (s_diff !== e.d || s_bout !== e.bo || s_ovf !== e.ov) begin
            bad++; $display("FAIL rnd_result got=%h/%b/%b want=%h/%b/%b", s_diff, s_bout, s_ovf, e.d, e.bo, e.ov);
          end
        end
      end
      if (sent == 1000 && q.size() == 0) break;
    end
    total++; if (sent != 1000 || q.size() != 0) begin bad++; $display("FAIL rnd_drain sent=%0d left=%0d want=1000/0", sent, q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic acc, emit, seen;
    int   n;
    n = 0;
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 16'h4000 + j[15:0], 16'h0010, 1'b0, 1'b0, acc, emit);
      if (acc) n++;
    end
    total++; if (n != 3) begin bad++; $display("FAIL mid_accepts got=%0d want=3", n); end
    rst_nx = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, acc, emit);
    rst_nx = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1, acc, emit);
    total++; if (s_ovalid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", s_ovalid); end
    total++; if (s_diff !== 16'h0000) begin bad++; $display("FAIL mid_diff got=%h want=0000", s_diff); end
    total++; if (s_iready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", s_iready); end
    q.delete();
    seen = 1'b0;
    repeat (10) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, emit);
      if (s_ovalid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_ghost out_valid=%b want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
